// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and width helpers for the write-back L1 data cache
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WB,
        ST_FILL
    } cache_st_e;

    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int tag_w(input int addr_w, input int sets, input int line_words);
        return addr_w - $clog2(sets) - $clog2(line_words) - 2;
    endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// rtl/cache_victim_sel.sv - picks the way to replace: lowest invalid way, else the LRU way
module cache_victim_sel
    import cache_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int WAY_W = way_w(WAYS)
) (
    input  logic [WAYS-1:0]  valid,
    input  logic             lru,
    output logic [WAY_W-1:0] victim
);

    always_comb begin
        victim = '0;
        if (WAYS > 1) begin
            victim = WAY_W'(lru);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                victim = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/cache_nway_wb_ctrl.sv
// rtl/cache_nway_wb_ctrl.sv - set-associative write-back/write-allocate L1 data cache with L2 burst FSM
module cache_nway_wb_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WAYS       = 2,
    parameter int SETS       = 512,
    parameter int LINE_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              l2_req,
    output logic              l2_we,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [DATA_W-1:0] l2_wdata,
    input  logic [DATA_W-1:0] l2_rdata,
    input  logic              l2_ack,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    localparam int IDX_W = $clog2(SETS);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int TAG_W = tag_w(ADDR_W, SETS, LINE_WORDS);
    localparam int WAY_W = way_w(WAYS);

    logic [DATA_W-1:0] data_arr  [WAYS][SETS][LINE_WORDS];
    logic [TAG_W-1:0]  tag_arr   [WAYS][SETS];
    logic [WAYS-1:0]   valid_arr [SETS];
    logic [WAYS-1:0]   dirty_arr [SETS];
    logic              lru_arr   [SETS];

    cache_st_e         state;
    logic [OFF_W-1:0]  beat;
    logic [WAY_W-1:0]  vic_way;
    logic [TAG_W-1:0]  miss_tag;
    logic [IDX_W-1:0]  miss_idx;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_word;
    logic              unused_addr_bits;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim;
    logic              beat_last;

    assign req_tag          = cpu_addr[ADDR_W-1 -: TAG_W];
    assign req_idx          = cpu_addr[OFF_W+2 +: IDX_W];
    assign req_word         = cpu_addr[2 +: OFF_W];
    assign unused_addr_bits = ^cpu_addr[1:0];
    assign beat_last        = (beat == OFF_W'(LINE_WORDS - 1));

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_arr[req_idx][w] && (tag_arr[w][req_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    cache_victim_sel #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_victim_sel (
        .valid  (valid_arr[req_idx]),
        .lru    (lru_arr[req_idx]),
        .victim (victim)
    );

    // Lookups only happen in IDLE; the held request re-looks-up after a fill completes.
    assign cpu_ready = (state == ST_IDLE) && cpu_req && hit && !rst;
    assign cpu_rdata = data_arr[hit_way][req_idx][req_word];

    always_comb begin
        l2_req   = (state != ST_IDLE);
        l2_we    = (state == ST_WB);
        l2_addr  = '0;
        l2_wdata = '0;
        if (state == ST_WB) begin
            l2_addr  = {tag_arr[vic_way][miss_idx], miss_idx, beat, 2'b00};
            l2_wdata = data_arr[vic_way][miss_idx][beat];
        end else if (state == ST_FILL) begin
            l2_addr  = {miss_tag, miss_idx, beat, 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            beat     <= '0;
            vic_way  <= '0;
            miss_tag <= '0;
            miss_idx <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
                lru_arr[s]   <= 1'b0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_req && hit) begin
                        hit_cnt          <= hit_cnt + 32'd1;
                        lru_arr[req_idx] <= (hit_way == '0);
                        if (cpu_we) begin
                            dirty_arr[req_idx][hit_way] <= 1'b1;
                        end
                    end else if (cpu_req) begin
                        miss_cnt <= miss_cnt + 32'd1;
                        vic_way  <= victim;
                        miss_tag <= req_tag;
                        miss_idx <= req_idx;
                        beat     <= '0;
                        state    <= (valid_arr[req_idx][victim] && dirty_arr[req_idx][victim])
                                    ? ST_WB : ST_FILL;
                    end
                end
                ST_WB: begin
                    if (l2_ack) begin
                        beat <= beat_last ? '0 : beat + OFF_W'(1);
                        if (beat_last) begin
                            state <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (l2_ack) begin
                        beat <= beat_last ? '0 : beat + OFF_W'(1);
                        if (beat_last) begin
                            valid_arr[miss_idx][vic_way] <= 1'b1;
                            dirty_arr[miss_idx][vic_way] <= 1'b0;
                            state                        <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Data and tag storage carry no reset; validity alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (cpu_ready && cpu_we) begin
                data_arr[hit_way][req_idx][req_word] <= cpu_wdata;
            end
            if ((state == ST_FILL) && l2_ack) begin
                data_arr[vic_way][miss_idx][beat] <= l2_rdata;
                if (beat_last) begin
                    tag_arr[vic_way][miss_idx] <= miss_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_nway_wb_ctrl.sv
// tb/tb_cache_nway_wb_ctrl.sv - randomized self-checking bench for cache_nway_wb_ctrl against a line-level cache model
module tb_cache_nway_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst, cpu_req, cpu_we, l2_ack, sel;
    logic [31:0] cpu_addr, cpu_wdata, l2_rdata;

    logic        req0, req1;
    logic [31:0] rdata0, rdata1, l2_addr0, l2_addr1, l2_wdata0, l2_wdata1;
    logic [31:0] hit0, hit1, miss0, miss1;
    logic        ready0, ready1, l2_req0, l2_req1, l2_we0, l2_we1;

    logic [31:0] rdata_m, l2_addr_m, l2_wdata_m, hit_m, miss_m;
    logic        ready_m, l2_req_m, l2_we_m;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;
    beat_t got_q[$];
    beat_t exp_q[$];

    int          m_ways, m_sets, m_sh;
    bit          m_valid [2][512];
    bit          m_dirty [2][512];
    logic [31:0] m_tag   [2][512];
    logic [31:0] m_data  [2][512][8];
    longint      m_time  [2][512];
    longint      now;
    int          exp_hit, exp_miss;

    always #5 clk = ~clk;

    assign req0 = cpu_req & ~sel;
    assign req1 = cpu_req & sel;

    cache_nway_wb_ctrl u_dut0 (
        .clk(clk), .rst(rst), .cpu_req(req0), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(rdata0), .cpu_ready(ready0), .l2_req(l2_req0),
        .l2_we(l2_we0), .l2_addr(l2_addr0), .l2_wdata(l2_wdata0), .l2_rdata(l2_rdata),
        .l2_ack(l2_ack), .hit_cnt(hit0), .miss_cnt(miss0)
    );

    cache_nway_wb_ctrl #(.WAYS(1), .SETS(4)) u_dut1 (
        .clk(clk), .rst(rst), .cpu_req(req1), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(rdata1), .cpu_ready(ready1), .l2_req(l2_req1),
        .l2_we(l2_we1), .l2_addr(l2_addr1), .l2_wdata(l2_wdata1), .l2_rdata(l2_rdata),
        .l2_ack(l2_ack), .hit_cnt(hit1), .miss_cnt(miss1)
    );

    always_comb begin
        rdata_m    = sel ? rdata1    : rdata0;
        ready_m    = sel ? ready1    : ready0;
        l2_req_m   = sel ? l2_req1   : l2_req0;
        l2_we_m    = sel ? l2_we1    : l2_we0;
        l2_addr_m  = sel ? l2_addr1  : l2_addr0;
        l2_wdata_m = sel ? l2_wdata1 : l2_wdata0;
        hit_m      = sel ? hit1      : hit0;
        miss_m     = sel ? miss1     : miss0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int w = 0; w < 2; w++) begin
            for (int s = 0; s < 512; s++) begin
                m_valid[w][s] = 1'b0;
                m_dirty[w][s] = 1'b0;
                m_time[w][s]  = 0;
            end
        end
        exp_hit  = 0;
        exp_miss = 0;
        now      = 0;
    endfunction

    function automatic logic [31:0] mk_addr(input logic [31:0] tag, input int idx, input int w);
        return (tag << m_sh) | 32'(idx << 5) | 32'(w << 2);
    endfunction

    task automatic do_reset();
        rst     = 1'b1;
        cpu_req = 1'b0;
        l2_ack  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic check_reset_state(input string pfx);
        #1;
        check({pfx, "_cpu_ready"}, 32'(ready_m), 32'd0);
        check({pfx, "_l2_req"}, 32'(l2_req_m), 32'd0);
        check({pfx, "_l2_we"}, 32'(l2_we_m), 32'd0);
        check({pfx, "_l2_addr"}, l2_addr_m, 32'd0);
        check({pfx, "_l2_wdata"}, l2_wdata_m, 32'd0);
        check({pfx, "_hit_cnt"}, hit_m, 32'd0);
        check({pfx, "_miss_cnt"}, miss_m, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // One CPU access: predict the L2 traffic and result from the model, then run it with random ack delays.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int maxd, output logic [31:0] rd);
        logic [31:0] tag, a, exp_rd;
        int idx, word, way, cyc, nwait, dly, ready_cyc;
        bit miss, done;
        tag  = addr >> m_sh;
        idx  = int'((addr >> 5) & 32'(m_sets - 1));
        word = int'(addr[4:2]);
        exp_q.delete();
        got_q.delete();
        way = -1;
        for (int w = 0; w < m_ways; w++)
            if (m_valid[w][idx] && m_tag[w][idx] == tag) way = w;
        miss = (way < 0);
        if (miss) begin
            exp_miss++;
            for (int w = m_ways - 1; w >= 0; w--)
                if (!m_valid[w][idx]) way = w;
            if (way < 0) begin
                way = 0;
                for (int w = 1; w < m_ways; w++)
                    if (m_time[w][idx] < m_time[way][idx]) way = w;
            end
            if (m_valid[way][idx] && m_dirty[way][idx])
                for (int b = 0; b < 8; b++)
                    exp_q.push_back('{1'b1, mk_addr(m_tag[way][idx], idx, b), m_data[way][idx][b]});
            for (int b = 0; b < 8; b++) begin
                a = mk_addr(tag, idx, b);
                exp_q.push_back('{1'b0, a, 32'hA000_0000 | a});
                m_data[way][idx][b] = 32'hA000_0000 | a;
            end
            m_tag[way][idx]   = tag;
            m_valid[way][idx] = 1'b1;
            m_dirty[way][idx] = 1'b0;
        end
        exp_hit++;
        now++;
        m_time[way][idx] = now;
        exp_rd = m_data[way][idx][word];
        if (we) begin
            m_data[way][idx][word] = wdata;
            m_dirty[way][idx]      = 1'b1;
        end

        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_req   = 1'b1;
        cyc = 0; nwait = 0; done = 0; ready_cyc = -1; rd = 32'hx;
        dly = int'($urandom_range(0, maxd));
        while (!done && cyc < 1000) begin
            #1;
            if (ready_m) begin
                done      = 1;
                ready_cyc = cyc;
                rd        = rdata_m;
            end else if (l2_req_m) begin
                if (dly == 0) begin
                    l2_ack   = 1'b1;
                    l2_rdata = 32'hA000_0000 | l2_addr_m;
                    got_q.push_back('{l2_we_m, l2_addr_m, l2_wdata_m});
                    dly = int'($urandom_range(0, maxd));
                end else begin
                    dly--;
                    nwait++;
                end
            end
            @(posedge clk);
            #1;
            l2_ack = 1'b0;
            cyc++;
        end
        cpu_req = 1'b0;

        check("ready_seen", 32'(done), 32'd1);
        check("latency", 32'(ready_cyc), miss ? 32'(1 + exp_q.size() + nwait) : 32'd0);
        check("nbeats", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("beat%0d_we", i), 32'(got_q[i].we), 32'(exp_q[i].we));
            check($sformatf("beat%0d_addr", i), got_q[i].addr, exp_q[i].addr);
            if (exp_q[i].we) check($sformatf("beat%0d_wdata", i), got_q[i].data, exp_q[i].data);
        end
        if (!we) check("rdata", rd, exp_rd);
        check("hit_cnt", hit_m, 32'(exp_hit));
        check("miss_cnt", miss_m, 32'(exp_miss));
    endtask

    function automatic logic [31:0] rand_addr();
        int idx;
        if (sel) begin
            idx = int'($urandom_range(0, 3));
        end else begin
            case ($urandom_range(0, 2))
                0:       idx = 'h80;
                1:       idx = 'h81;
                default: idx = 'h1FF;
            endcase
        end
        return mk_addr(32'($urandom_range(0, 3)), idx, int'($urandom_range(0, 7)))
               | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int acks;
        sel = 1'b0; m_ways = 2; m_sets = 512; m_sh = 14;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        l2_ack = 1'b0; l2_rdata = '0;
        do_reset();
        check_reset_state("rst0");

        access(1'b0, 32'h0000_1004, 32'h0, 0, rd);
        check("t1_rdata", rd, 32'hA000_1004);
        check("t1_miss_cnt", miss_m, 32'd1);
        access(1'b1, 32'h0000_1008, 32'hDEAD_BEEF, 0, rd);
        check("t2_store_beats", 32'(got_q.size()), 32'd0);
        access(1'b0, 32'h0000_1008, 32'h0, 0, rd);
        check("t2_rdata", rd, 32'hDEAD_BEEF);
        access(1'b0, 32'h0000_5000, 32'h0, 0, rd);
        access(1'b0, 32'h0000_9000, 32'h0, 0, rd);
        check("t3_rdata", rd, 32'hA000_9000);
        check("t3_nbeats", 32'(got_q.size()), 32'd16);
        if (got_q.size() == 16) begin
            check("t3_wb0_addr", got_q[0].addr, 32'h0000_1000);
            check("t3_wb2_data", got_q[2].data, 32'hDEAD_BEEF);
            check("t3_fill0_addr", got_q[8].addr, 32'h0000_9000);
        end

        repeat (60) access(1'($urandom_range(0, 1)), rand_addr(), $urandom, 5, rd);

        do_reset();
        cpu_we = 1'b0; cpu_addr = 32'h0000_1004; cpu_req = 1'b1;
        acks = 0;
        for (int c = 0; c < 50 && acks < 3; c++) begin
            #1;
            if (l2_req_m) begin
                l2_ack   = 1'b1;
                l2_rdata = 32'hA000_0000 | l2_addr_m;
                acks++;
            end
            @(posedge clk);
            #1;
            l2_ack = 1'b0;
        end
        check("t5_acks_before_rst", 32'(acks), 32'd3);
        check("t5_l2_req_in_fill", 32'(l2_req_m), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_l2_req_after_rst", 32'(l2_req_m), 32'd0);
        rst = 1'b0; cpu_req = 1'b0;
        model_clear();
        check("t5_miss_cnt_cleared", miss_m, 32'd0);
        access(1'b0, 32'h0000_1004, 32'h0, 2, rd);
        check("t5_remiss_cnt", miss_m, 32'd1);
        check("t5_rdata", rd, 32'hA000_1004);

        sel = 1'b1; m_ways = 1; m_sets = 4; m_sh = 7;
        do_reset();
        check_reset_state("rst1");
        access(1'b0, 32'h0000_0000, 32'h0, 0, rd);
        access(1'b0, 32'h0000_0080, 32'h0, 0, rd);
        check("t6_nbeats", 32'(got_q.size()), 32'd8);
        check("t6_rdata", rd, 32'hA000_0080);
        access(1'b0, 32'h0000_0000, 32'h0, 1, rd);
        check("t6_miss_cnt", miss_m, 32'd3);
        repeat (30) access(1'($urandom_range(0, 1)), rand_addr(), $urandom, 3, rd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
